// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and timing helpers for the RSA decryption ladder
package rsa_pkg;

    // Controller phases of one decryption
    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        LADDER,
        FINISH
    } state_e;

    // Cycles taken by one modular multiplication: launch + one per multiplier bit
    function automatic int op_cycles(input int width);
        return 2 * width + 1;
    endfunction

    // Start-accept to done: one reduction plus one op per exponent bit, plus FINISH
    function automatic int lat_cycles(input int width);
        return op_cycles(width) * (2 * width + 1) + 1;
    endfunction

    // Bits needed to index every exponent bit during the ladder
    function automatic int step_bits(input int width);
        return $clog2(2 * width);
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int OP            = op_cycles(DEFAULT_WIDTH);
    localparam int LAT           = lat_cycles(DEFAULT_WIDTH);

endpackage

// File: rtl/rsa_modmul.sv
// rtl/rsa_modmul.sv - fixed-latency interleaved shift-add modular multiplier
module rsa_modmul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   res,
    output logic                 res_valid
);

    localparam int NB = 2 * WIDTH;
    // Two extra bits so 2*acc + a (< 3n) never wraps
    localparam int AW = NB + 2;
    localparam int CW = $clog2(NB + 1);

    logic [NB-1:0] a_q, a_d;
    logic [NB-1:0] b_q, b_d;
    logic [NB-1:0] n_q, n_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [NB-1:0] res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic [AW-1:0] acc_nx;
    logic [AW-1:0] nx;

    // One MSB-first iteration: double, add a on a set bit, fold back below n twice
    always_comb begin
        nx     = {2'b00, n_q};
        acc_nx = (acc_q << 1) + (b_q[NB-1] ? {2'b00, a_q} : '0);
        if (acc_nx >= nx) begin
            acc_nx = acc_nx - nx;
        end
        if (acc_nx >= nx) begin
            acc_nx = acc_nx - nx;
        end
    end

    // Operand capture on go, then exactly NB iterations with no data-dependent exit
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        n_d         = n_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        if (go) begin
            a_d    = a;
            b_d    = b;
            n_d    = n;
            acc_d  = '0;
            cnt_d  = CW'(NB);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_nx;
            b_d   = b_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d      = 1'b0;
                res_d       = acc_nx[NB-1:0];
                res_valid_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;

endmodule

// File: rtl/rsa_decrypt_ladder.sv
// rtl/rsa_decrypt_ladder.sv - constant-time m = c^d mod n via Montgomery ladder
module rsa_decrypt_ladder
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   c,
    input  logic [2*WIDTH-1:0]   d,
    input  logic [2*WIDTH-1:0]   n,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   m_out,
    output logic                 err
);

    localparam int NB = 2 * WIDTH;
    localparam int SW = step_bits(WIDTH);

    state_e        state_q, state_d;
    logic [NB-1:0] c_q, c_d;
    logic [NB-1:0] d_q, d_d;
    logic [NB-1:0] n_q, n_d;
    logic [NB-1:0] r0_q, r0_d;
    logic [NB-1:0] r1_q, r1_d;
    logic [SW-1:0] step_q, step_d;
    logic          launch_q, launch_d;
    logic [NB-1:0] m_out_q, m_out_d;
    logic          err_q, err_d;

    logic          go0, go1;
    logic [NB-1:0] a0, b0, a1, b1;
    logic [NB-1:0] res0, res1;
    logic          rv0, rv1;
    logic          issue;
    logic [NB-1:0] one_mod;

    // Instance 0 does the initial reduction and the R0*R1 cross product
    rsa_modmul #(.WIDTH(WIDTH)) u_mm0 (
        .clk       (clk),
        .rst       (rst),
        .go        (go0),
        .a         (a0),
        .b         (b0),
        .n         (n_q),
        .res       (res0),
        .res_valid (rv0)
    );

    // Instance 1 squares whichever register the exponent bit selects
    rsa_modmul #(.WIDTH(WIDTH)) u_mm1 (
        .clk       (clk),
        .rst       (rst),
        .go        (go1),
        .a         (a1),
        .b         (b1),
        .n         (n_q),
        .res       (res1),
        .res_valid (rv1)
    );

    // Sequencing and ladder register updates; the next op launches in the
    // same cycle a result lands, fed from the updated values, so every step
    // costs exactly one multiplier period regardless of the data
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        n_d      = n_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        step_d   = step_q;
        launch_d = 1'b0;
        m_out_d  = m_out_q;
        err_d    = err_q;
        go0      = 1'b0;
        go1      = 1'b0;
        a0       = '0;
        b0       = '0;
        a1       = '0;
        b1       = '0;
        issue    = 1'b0;
        one_mod  = (n_q == NB'(1)) ? '0 : NB'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d      = c;
                    d_d      = d;
                    n_d      = n;
                    launch_d = 1'b1;
                    state_d  = REDUCE;
                end
            end
            REDUCE: begin
                if (launch_q) begin
                    go0 = 1'b1;
                    a0  = NB'(1);
                    b0  = c_q;
                end else if (rv0) begin
                    r0_d    = one_mod;
                    r1_d    = res0;
                    step_d  = SW'(NB - 1);
                    state_d = LADDER;
                    issue   = 1'b1;
                end
            end
            LADDER: begin
                if (rv0 && rv1) begin
                    if (d_q[step_q]) begin
                        r0_d = res0;
                        r1_d = res1;
                    end else begin
                        r0_d = res1;
                        r1_d = res0;
                    end
                    if (step_q == '0) begin
                        state_d = FINISH;
                        m_out_d = (n_q == '0) ? '0 : r0_d;
                        err_d   = (n_q == '0);
                    end else begin
                        step_d = step_q - 1'b1;
                        issue  = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            go0 = 1'b1;
            go1 = 1'b1;
            a0  = r0_d;
            b0  = r1_d;
            a1  = d_q[step_d] ? r1_d : r0_d;
            b1  = a1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            step_q   <= '0;
            launch_q <= 1'b0;
            m_out_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            n_q      <= n_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            step_q   <= step_d;
            launch_q <= launch_d;
            m_out_q  <= m_out_d;
            err_q    <= err_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == FINISH);
    assign m_out = m_out_q;
    assign err   = err_q;

endmodule
